// File: rtl/first_test_pkg.sv
// first_test_pkg: shared widths and types for the first bring-up block
package first_test_pkg;
    localparam int COUNT_W_DEFAULT = 8;
    typedef logic [COUNT_W_DEFAULT-1:0] count_t;
endpackage

// File: rtl/event_counter.sv
// event_counter: wrapping event counter with asynchronous clear
module event_counter
    import first_test_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    output logic [COUNT_W-1:0] count
);
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (inc) count <= count + 1'b1;
endmodule

// File: rtl/first_test_core.sv
// first_test_core: registered AND of two inputs plus a count of matching cycles
module first_test_core
    import first_test_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_in,
    input  logic               b_in,
    output logic               c_out,
    output logic [COUNT_W-1:0] counter
);
    logic match;
    assign match = a_in & b_in;
    always_ff @(posedge clk or posedge rst)
        if (rst) c_out <= 1'b0;
        else c_out <= match;
    event_counter #(.COUNT_W(COUNT_W)) u_cnt (
        .clk(clk),
        .rst(rst),
        .inc(match),
        .count(counter)
    );
endmodule

// File: tb/tb_first_test_core.sv
// tb_first_test_core: directed scoreboard bench for first_test_core
module tb_first_test_core;
    import first_test_pkg::*;
    typedef struct {
        string  tag;
        logic   c;
        count_t cnt;
    } exp_t;
    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   a_in = 1'b1;
    logic   b_in = 1'b1;
    logic   c_out;
    count_t counter;
    exp_t   sb[$];
    logic   m_c = 1'b0;
    count_t m_cnt = '0;
    int     n_chk = 0;
    int     n_fail = 0;

    first_test_core #(.COUNT_W(COUNT_W_DEFAULT)) dut (
        .clk(clk),
        .rst(rst),
        .a_in(a_in),
        .b_in(b_in),
        .c_out(c_out),
        .counter(counter)
    );

    always #5 clk = ~clk;

    task automatic check_head();
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        n_chk++;
        assert (c_out === e.c) else begin
            n_fail++;
            $error("FAIL %s c_out observed=%0b expected=%0b", e.tag, c_out, e.c);
        end
        n_chk++;
        assert (counter === e.cnt) else begin
            n_fail++;
            $error("FAIL %s counter observed=%0d expected=%0d", e.tag, counter, e.cnt);
        end
    endtask

    // Called at a falling edge: drive, model the next rising edge, check 1ns after it.
    task automatic step(input logic a, input logic b, input string tag);
        a_in = a;
        b_in = b;
        m_c = a & b;
        if (a & b) m_cnt = m_cnt + 1'b1;
        sb.push_back('{tag, m_c, m_cnt});
        @(posedge clk);
        #1;
        check_head();
        @(negedge clk);
    endtask

    // Asserts reset at a falling edge with both inputs high, holds two edges, releases.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        a_in = 1'b1;
        b_in = 1'b1;
        m_c = 1'b0;
        m_cnt = '0;
        #1;
        sb.push_back('{{tag, "_assert"}, 1'b0, count_t'(0)});
        check_head();
        repeat (2) begin
            @(posedge clk);
            #1;
            sb.push_back('{{tag, "_hold"}, 1'b0, count_t'(0)});
            check_head();
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1;
        sb.push_back('{"por", 1'b0, count_t'(0)});
        check_head();
        @(posedge clk);
        #1;
        sb.push_back('{"por_hold", 1'b0, count_t'(0)});
        check_head();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, "idle_25");
        step(1'b1, 1'b1, "edge_35");
        step(1'b0, 1'b0, "edge_45");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, "edge_55_95");
        n_chk++;
        assert (counter === count_t'(6)) else begin
            n_fail++;
            $error("FAIL count_at_95 observed=%0d expected=6", counter);
        end
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "a_only");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "b_only");
        step(1'b1, 1'b1, "single_match");
        step(1'b0, 1'b0, "single_match_drop");
        do_reset("wrap_rst");
        for (int i = 0; i < 256; i++) step(1'b1, 1'b1, i == 255 ? "wrap_zero" : "wrap_run");
        do_reset("mid_rst");
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, "to_ten");
        @(posedge clk);
        #3;
        rst = 1'b1;
        m_c = 1'b0;
        m_cnt = '0;
        #1;
        sb.push_back('{"async_clear", 1'b0, count_t'(0)});
        check_head();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1, "after_release");
        n_chk++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
